// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flop, one operand
// bit per clock LSB first, under a start/done handshake.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
    logic [WIDTH:0]   res_ext;
    logic [CNT_W-1:0] cnt;
    logic             carry, bit_s, last;

    function automatic logic majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // The widened concatenation keeps the result shift legal when WIDTH is 1.
    always_comb begin
        bit_s    = a_sr[0] ^ b_sr[0] ^ carry;
        res_ext  = {bit_s, res_sr};
        res_next = res_ext[WIDTH:1];
        last     = (cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1, so the carry seeds to 1 and cin is dropped.
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    carry  <= majority(a_sr[0], b_sr[0], carry);
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        sum  <= res_next;
                        cout <= majority(a_sr[0], b_sr[0], carry);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH = 1, 8 and 16, table-driven plus
// hand-written multi-cycle sequences (mid-run start, mid-run reset, back-to-back).
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, start1, sub1, cin1, a1, b1, busy1, done1, sum1, cout1;
    logic        rst8, start8, sub8, cin8, busy8, done8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        rst16, start16, sub16, cin16, busy16, done16, cout16;
    logic [15:0] a16, b16, sum16;

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .sub(sub1), .cin(cin1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));
    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .sub(sub8), .cin(cin8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst16), .start(start16), .sub(sub16), .cin(cin16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16));

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        int          w;
        logic        sub;
        logic        cin;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] es;
        logic        ec;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input int w, input logic st, input logic sb, input logic ci,
                          input logic [31:0] av, input logic [31:0] bv);
        case (w)
            1: begin start1 = st; sub1 = sb; cin1 = ci; a1 = av[0]; b1 = bv[0]; end
            8: begin start8 = st; sub8 = sb; cin8 = ci; a8 = av[7:0]; b8 = bv[7:0]; end
            default: begin start16 = st; sub16 = sb; cin16 = ci; a16 = av[15:0]; b16 = bv[15:0]; end
        endcase
    endtask

    function automatic logic get_busy(input int w);
        case (w)
            1: return busy1;
            8: return busy8;
            default: return busy16;
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            1: return done1;
            8: return done8;
            default: return done16;
        endcase
    endfunction

    function automatic logic [31:0] get_sum(input int w);
        case (w)
            1: return {31'b0, sum1};
            8: return {24'b0, sum8};
            default: return {16'b0, sum16};
        endcase
    endfunction

    function automatic logic get_cout(input int w);
        case (w)
            1: return cout1;
            8: return cout8;
            default: return cout16;
        endcase
    endfunction

    // Called and returns #1 after a rising edge. lat counts cycles from accept to done.
    task automatic run_op(input int w, input logic sb, input logic ci,
                          input logic [31:0] av, input logic [31:0] bv,
                          output logic [31:0] rs, output logic rc,
                          output int lat, output int bcnt);
        int k;
        lat = -1; bcnt = 0; rs = '0; rc = 1'b0; k = 0;
        set_in(w, 1'b1, sb, ci, av, bv);
        while (!get_busy(w) && k < 12) begin
            @(posedge clk); #1; k++;
        end
        set_in(w, 1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom);
        if (!get_busy(w)) return;
        for (int c = 0; c < 40; c++) begin
            if (get_done(w)) begin
                lat = c;
                break;
            end
            if (get_busy(w)) bcnt++;
            @(posedge clk); #1;
        end
        rs = get_sum(w);
        rc = get_cout(w);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rs, av, bv, es, tmp;
        logic        rc, sb, ci, ec;
        int          lat, bcnt, ndone, prev;

        vecs[0]  = '{"w8 add ff+01",    8,  1'b0, 1'b0, 32'hFF,   32'h01,   32'h00,   1'b1};
        vecs[1]  = '{"w8 add 5a+25+1",  8,  1'b0, 1'b1, 32'h5A,   32'h25,   32'h80,   1'b0};
        vecs[2]  = '{"w8 add 00+00",    8,  1'b0, 1'b0, 32'h00,   32'h00,   32'h00,   1'b0};
        vecs[3]  = '{"w8 sub 05-03",    8,  1'b1, 1'b1, 32'h05,   32'h03,   32'h02,   1'b1};
        vecs[4]  = '{"w8 sub 03-05",    8,  1'b1, 1'b1, 32'h03,   32'h05,   32'hFE,   1'b0};
        vecs[5]  = '{"w1 0+0",          1,  1'b0, 1'b0, 32'h0,    32'h0,    32'h0,    1'b0};
        vecs[6]  = '{"w1 1+0",          1,  1'b0, 1'b0, 32'h1,    32'h0,    32'h1,    1'b0};
        vecs[7]  = '{"w1 0+1",          1,  1'b0, 1'b0, 32'h0,    32'h1,    32'h1,    1'b0};
        vecs[8]  = '{"w1 1+1",          1,  1'b0, 1'b0, 32'h1,    32'h1,    32'h0,    1'b1};
        vecs[9]  = '{"w1 1+1+1",        1,  1'b0, 1'b1, 32'h1,    32'h1,    32'h1,    1'b1};
        vecs[10] = '{"w16 add max+1",   16, 1'b0, 1'b1, 32'hFFFF, 32'hFFFF, 32'hFFFF, 1'b1};
        vecs[11] = '{"w16 sub equal",   16, 1'b1, 1'b0, 32'h1234, 32'h1234, 32'h0000, 1'b1};
        vecs[12] = '{"w16 sub 0-1",     16, 1'b1, 1'b0, 32'h0000, 32'h0001, 32'hFFFF, 1'b0};
        vecs[13] = '{"w8 add 80+80",    8,  1'b0, 1'b0, 32'h80,   32'h80,   32'h00,   1'b1};

        rst1 = 1'b1; rst8 = 1'b1; rst16 = 1'b1;
        set_in(1, 1'b0, 1'b0, 1'b0, 0, 0);
        set_in(8, 1'b0, 1'b0, 1'b0, 0, 0);
        set_in(16, 1'b0, 1'b0, 1'b0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) begin end
        for (int w = 1; w <= 16; w = (w == 1) ? 8 : 16 + w) begin
            chk($sformatf("w%0d reset busy", w), {31'b0, get_busy(w)}, 32'h0);
            chk($sformatf("w%0d reset done", w), {31'b0, get_done(w)}, 32'h0);
            chk($sformatf("w%0d reset sum", w),  get_sum(w), 32'h0);
            chk($sformatf("w%0d reset cout", w), {31'b0, get_cout(w)}, 32'h0);
        end
        rst1 = 1'b0; rst8 = 1'b0; rst16 = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].w, vecs[i].sub, vecs[i].cin, vecs[i].a, vecs[i].b, rs, rc, lat, bcnt);
            chk({vecs[i].name, " sum"}, rs, vecs[i].es);
            chk({vecs[i].name, " cout"}, {31'b0, rc}, {31'b0, vecs[i].ec});
            chk({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].w));
            chk({vecs[i].name, " busy cycles"}, 32'(bcnt), 32'(vecs[i].w));
        end

        // start re-pulsed three cycles into RUN must be ignored
        @(posedge clk); #1;
        @(posedge clk); #1;
        set_in(8, 1'b1, 1'b0, 1'b0, 32'h10, 32'h20);
        @(posedge clk); #1;
        set_in(8, 1'b0, 1'b0, 1'b0, 0, 0);
        lat = -1; ndone = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 2) set_in(8, 1'b1, 1'b0, 1'b0, 32'h11, 32'h22);
            if (c == 3) set_in(8, 1'b0, 1'b0, 1'b0, 0, 0);
            if (done8) begin
                ndone++;
                if (lat < 0) lat = c;
            end
            @(posedge clk); #1;
        end
        chk("midrun start latency", 32'(lat), 32'd8);
        chk("midrun start done count", 32'(ndone), 32'd1);
        chk("midrun start sum", {24'b0, sum8}, 32'h30);
        chk("midrun start cout", {31'b0, cout8}, 32'h0);

        // reset in the fourth RUN cycle aborts the operation
        set_in(8, 1'b1, 1'b0, 1'b0, 32'hFF, 32'hFF);
        @(posedge clk); #1;
        set_in(8, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("abort accepted", {31'b0, busy8}, 32'h1);
        repeat (3) begin @(posedge clk); #1; end
        rst8 = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0;
        chk("abort busy", {31'b0, busy8}, 32'h0);
        chk("abort done", {31'b0, done8}, 32'h0);
        chk("abort sum", {24'b0, sum8}, 32'h0);
        chk("abort cout", {31'b0, cout8}, 32'h0);
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            if (done8) ndone++;
            @(posedge clk); #1;
        end
        chk("abort no done pulse", 32'(ndone), 32'd0);

        // WIDTH=16 random sweep against a golden model
        for (int i = 0; i < 100; i++) begin
            av = $urandom & 32'hFFFF;
            bv = $urandom & 32'hFFFF;
            sb = i[0];
            ci = 1'($urandom);
            if (sb) begin
                es = (av - bv) & 32'hFFFF;
                ec = (av >= bv);
            end else begin
                tmp = av + bv + {31'b0, ci};
                es = tmp & 32'hFFFF;
                ec = tmp[16];
            end
            run_op(16, sb, ci, av, bv, rs, rc, lat, bcnt);
            chk($sformatf("rand%0d sum a=%0h b=%0h sub=%0d", i, av, bv, sb), rs, es);
            chk($sformatf("rand%0d cout a=%0h b=%0h sub=%0d", i, av, bv, sb), {31'b0, rc}, {31'b0, ec});
        end

        // start held high: completions every WIDTH+2 cycles
        set_in(16, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h0101);
        prev = -1; ndone = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (done16) begin
                if (prev >= 0) chk($sformatf("done spacing %0d", ndone), 32'(c - prev), 32'd18);
                prev = c;
                ndone++;
            end
        end
        set_in(16, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("held start done count", 32'(ndone >= 4), 32'd1);
        chk("held start sum", {16'b0, sum16}, 32'h1335);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
